prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time loader that fills the instruction memory from a byte stream, for example a UART receiver. It sits between the byte source and the write port of the writable program memory, and holds the RISC-V core in reset until the image is complete. It receives a framed image (magic byte, word count, little-endian words), assembles 32-bit words, and issues one write per word at consecutive word-aligned addresses starting at 0. It then releases the core.

## Interface

Parameters:
- MEM_SIZE, 256, program memory depth in 32-bit words; the largest word count the loader accepts.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_en  output  1  one-cycle program-memory write strobe.
- wr_addr  output  32  byte address of the write; always a multiple of 4.
- wr_data  output  32  word to write.
- cpu_rst  output  1  core reset; high while loading.
- done  output  1  high once the image is fully written; sticky until rst.
- error  output  1  high when the word count is illegal; sticky until rst.

## Operation

- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, done=0, error=0, state=IDLE, word index=0, byte index=0.
- State machine: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR.
- IDLE: a valid byte equal to MAGIC moves to LEN_LO. All other bytes are discarded.
- LEN_LO: latch the byte as count[7:0], go to LEN_HI.
- LEN_HI: latch the byte as count[15:8] and evaluate the 16-bit count:
  - count=0: go to DONE.
  - count>MEM_SIZE: go to ERROR.
  - otherwise: go to DATA with word index=0 and byte index=0.
- DATA assembles bytes little-endian: byte k (k=0..3) goes into word bits [8k+7:8k].
- On the 4th byte of a word:
  - register wr_data = the assembled word and wr_addr = word_index*4, and pulse wr_en.
  - increment word index; byte index wraps to 0.
- When the final word's write is issued, the next state is DONE.
- DONE: cpu_rst=0, done=1. All further rx bytes are ignored, including MAGIC. Reloading requires rst.
- ERROR: error=1, cpu_rst stays 1, no writes. All rx bytes are ignored until rst.
- The word index is 16 bits wide. Address arithmetic is zero-extended to 32 bits, so the maximum wr_addr is (MEM_SIZE-1)*4.
- Bytes with rx_valid=0 have no effect in any state. There is no timeout: a partial frame waits indefinitely.
- Reset mid-load: all state returns to reset values immediately (asynchronously). Partial words are discarded and cpu_rst stays 1. Words already written are not retracted. The next frame must start with MAGIC.

## Timing

- Byte acceptance: every state accepts rx_valid in any cycle, including back-to-back cycles (one byte per clock).
- Write latency: wr_en, wr_addr and wr_data are registered. They are valid in the cycle after the clock edge that samples the 4th byte of a word.
- wr_en is high for exactly one cycle per word. wr_addr and wr_data hold their values until the next write.
- Release latency:
  - done and cpu_rst change together, registered, in the same cycle as the last wr_en pulse.
  - The memory captures the final write at that cycle's closing edge. The core therefore leaves reset no earlier than the edge after the last write is committed.
- For count=0: done=1 and cpu_rst=0 in the cycle after the LEN_HI byte is sampled.
- For an illegal count: error=1 in the cycle after the LEN_HI byte is sampled.
- The memory port is write-only from the loader and has no backpressure. The program memory must accept one write per cycle.

## Test plan

1. **Two-word load.** Stream A5,02,00,13,00,00,00,93,00,80,02.
   - Required: wr_en pulses with (addr 0, data 0x00000013) then (addr 4, data 0x02800093).
   - done=1 and cpu_rst=0 in the same cycle as the second write; exactly 2 writes in total.
2. **Garbage prefix and gaps.** Stream 00,FF,5A, then frame 1 with random rx_valid gaps.
   - Required: the same two writes; the prefix causes no state change.
3. **Zero length and length boundaries.**
   - A5,00,00: no writes; done=1 in the cycle after the 3rd byte.
   - Count 256 of back-to-back bytes: 256 writes, last wr_addr=0x3FC, done=1.
4. **Oversize count.** A5,01,01 (count 257).
   - Required: error=1 in the cycle after the 3rd byte, cpu_rst=1, no wr_en; following bytes ignored.
5. **Reset mid-load.** Assert rst after the 6th byte of frame 1.
   - Required: outputs return to reset values asynchronously.
   - Then send frame 1 in full: writes restart at addr 0 with the correct data.
6. **Post-done immunity.** After test 1, stream A5,01,00,11,22,33,44.
   - Required: no wr_en; done stays 1 and cpu_rst stays 0.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The loader takes the slave modport; the byte source and memory side take the master modport.
interface prog_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_rst;
   logic        done;
   logic        error;

   modport slave (
      input  rx_data, rx_valid,
      output wr_en, wr_addr, wr_data, cpu_rst, done, error
   );

   modport master (
      output rx_data, rx_valid,
      input  wr_en, wr_addr, wr_data, cpu_rst, done, error
   );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a framed image (magic, 16-bit word count, little-endian words),
// writes each word to program memory at consecutive word addresses, then releases the core.
//
// state  | meaning
// IDLE   | discarding bytes until MAGIC is seen
// LEN_LO | next byte is count[7:0]
// LEN_HI | next byte is count[15:8]; count is checked here
// DATA   | assembling words and issuing one write per 4 bytes
// DONE   | image complete, core released, input ignored
// ERROR  | illegal count, core held in reset, input ignored
module prog_loader #(
   parameter int         MEM_SIZE = 256,
   parameter logic [7:0] MAGIC    = 8'hA5
) (
   input  logic          clk,
   input  logic          rst,
   prog_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] LP_MAX_COUNT = 17'(MEM_SIZE);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_count;
   logic [15:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_word;
   logic        r_wr_en;
   logic [31:0] r_wr_addr;
   logic [31:0] r_wr_data;
   logic        w_wr_fire;
   logic [15:0] w_len;

   assign w_len = {bus.rx_data, r_count[7:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr_fire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
               w_state_nxt = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (bus.rx_valid) begin
               w_state_nxt = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (bus.rx_valid) begin
               if (w_len == 16'd0) begin
                  w_state_nxt = S_DONE;
               end else if ({1'b0, w_len} > LP_MAX_COUNT) begin
                  w_state_nxt = S_ERROR;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.rx_valid && (r_byte_idx == 2'd3)) begin
               w_wr_fire = 1'b1;
               if (r_word_idx == (r_count - 16'd1)) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  w_state_nxt = S_DONE;
         S_ERROR: w_state_nxt = S_ERROR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count    <= 16'd0;
         r_word_idx <= 16'd0;
         r_byte_idx <= 2'd0;
         r_word     <= 24'd0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 32'd0;
         r_wr_data  <= 32'd0;
      end else begin
         r_wr_en <= w_wr_fire;
         if (bus.rx_valid) begin
            case (r_state)
               S_LEN_LO: r_count[7:0] <= bus.rx_data;
               S_LEN_HI: begin
                  r_count[15:8] <= bus.rx_data;
                  r_word_idx    <= 16'd0;
                  r_byte_idx    <= 2'd0;
               end
               S_DATA: begin
                  if (r_byte_idx == 2'd3) begin
                     r_wr_data  <= {bus.rx_data, r_word};
                     r_wr_addr  <= {14'd0, r_word_idx, 2'b00};
                     r_word_idx <= r_word_idx + 16'd1;
                     r_byte_idx <= 2'd0;
                  end else begin
                     case (r_byte_idx)
                        2'd0:    r_word[7:0]   <= bus.rx_data;
                        2'd1:    r_word[15:8]  <= bus.rx_data;
                        default: r_word[23:16] <= bus.rx_data;
                     endcase
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // done/error/cpu_rst come straight from the state register, so they are registered
   // and change in the same cycle as the final write pulse.
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.done    = (r_state == S_DONE);
   assign bus.error   = (r_state == S_ERROR);
   assign bus.cpu_rst = (r_state != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a frame-level reference model predicts every output
// each cycle, and a few literal expectations pin the write log of known frames.
module tb_prog_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   prog_loader_if bus ();

   prog_loader #(.MEM_SIZE(256), .MAGIC(8'hA5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: frame phase plus the list of data bytes received so far.
   int          m_phase = 0;  // 0 magic,1 len lo,2 len hi,3 data,4 done,5 error
   int          m_count = 0;
   int          m_nbytes = 0;
   logic [31:0] m_acc = 0;
   logic        exp_wr_en = 0;
   logic [31:0] exp_wr_addr = 0;
   logic [31:0] exp_wr_data = 0;

   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_count = 0; m_nbytes = 0; m_acc = 0;
         exp_wr_en = 0; exp_wr_addr = 0; exp_wr_data = 0;
      end else begin
         exp_wr_en = 0;
         if (bus.rx_valid) begin
            case (m_phase)
               0: if (bus.rx_data == 8'hA5) m_phase = 1;
               1: begin m_count = int'(bus.rx_data); m_phase = 2; end
               2: begin
                  m_count = m_count + 256 * int'(bus.rx_data);
                  if (m_count == 0) m_phase = 4;
                  else if (m_count > 256) m_phase = 5;
                  else begin m_phase = 3; m_nbytes = 0; m_acc = 0; end
               end
               3: begin
                  m_acc = m_acc | (32'(bus.rx_data) << (8 * (m_nbytes % 4)));
                  m_nbytes++;
                  if (m_nbytes % 4 == 0) begin
                     exp_wr_en   = 1;
                     exp_wr_addr = 32'((m_nbytes / 4 - 1) * 4);
                     exp_wr_data = m_acc;
                     m_acc       = 0;
                     if (m_nbytes / 4 == m_count) m_phase = 4;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      chk("wr_en", 32'(bus.wr_en), 32'(exp_wr_en));
      chk("wr_addr", bus.wr_addr, exp_wr_addr);
      chk("wr_data", bus.wr_data, exp_wr_data);
      chk("done", 32'(bus.done), 32'(m_phase == 4));
      chk("error", 32'(bus.error), 32'(m_phase == 5));
      chk("cpu_rst", 32'(bus.cpu_rst), 32'(m_phase != 4));
      if (bus.wr_en === 1'b1) begin
         log_addr.push_back(bus.wr_addr);
         log_data.push_back(bus.wr_data);
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_list(input logic [7:0] bytes[$], input int max_gap);
      foreach (bytes[i]) send(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
   endtask

   // Asserts rst between edges and checks the outputs drop to reset values before any edge.
   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("async wr_en", 32'(bus.wr_en), 32'd0);
      chk("async wr_addr", bus.wr_addr, 32'd0);
      chk("async wr_data", bus.wr_data, 32'd0);
      chk("async cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("async done", 32'(bus.done), 32'd0);
      chk("async error", 32'(bus.error), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic settle();
      repeat (3) begin @(posedge clk); #1; end
   endtask

   logic [7:0] frame1[$];
   logic [7:0] big[$];

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      frame1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h80, 8'h02};
      repeat (2) @(posedge clk);
      #1;
      chk("reset cpu_rst", 32'(bus.cpu_rst), 32'd1);
      chk("reset done", 32'(bus.done), 32'd0);
      do_reset();

      // Two-word load, then post-done immunity.
      send_list(frame1, 0);
      chk("t1 done same cycle as last write", 32'(bus.done & bus.wr_en & ~bus.cpu_rst), 32'd1);
      settle();
      chk("t1 writes", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("t1 addr0", log_addr[0], 32'h0);
         chk("t1 data0", log_data[0], 32'h00000013);
         chk("t1 addr1", log_addr[1], 32'h4);
         chk("t1 data1", log_data[1], 32'h02800093);
      end
      send_list('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
      settle();
      chk("t6 no extra writes", 32'(log_addr.size()), 32'd2);
      chk("t6 done", 32'(bus.done), 32'd1);
      chk("t6 cpu_rst", 32'(bus.cpu_rst), 32'd0);

      // Garbage prefix and random gaps.
      do_reset();
      send_list('{8'h00, 8'hFF, 8'h5A}, 2);
      send_list(frame1, 3);
      settle();
      chk("t2 writes", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("t2 data0", log_data[0], 32'h00000013);
         chk("t2 data1", log_data[1], 32'h02800093);
      end

      // Zero length.
      do_reset();
      send_list('{8'hA5, 8'h00, 8'h00}, 0);
      chk("t3 zero done next cycle", 32'(bus.done), 32'd1);
      settle();
      chk("t3 zero writes", 32'(log_addr.size()), 32'd0);

      // Full-size image, back to back.
      do_reset();
      big = '{8'hA5, 8'h00, 8'h01};
      for (int i = 0; i < 1024; i++) big.push_back(8'($urandom));
      send_list(big, 0);
      settle();
      chk("t3 full writes", 32'(log_addr.size()), 32'd256);
      if (log_addr.size() == 256) begin
         chk("t3 last addr", log_addr[255], 32'h3FC);
         chk("t3 last data", log_data[255], {big[1026], big[1025], big[1024], big[1023]});
      end
      chk("t3 full done", 32'(bus.done), 32'd1);

      // Oversize count.
      do_reset();
      send_list('{8'hA5, 8'h01, 8'h01}, 0);
      chk("t4 error next cycle", 32'(bus.error), 32'd1);
      send_list(frame1, 1);
      settle();
      chk("t4 no writes", 32'(log_addr.size()), 32'd0);
      chk("t4 cpu_rst", 32'(bus.cpu_rst), 32'd1);

      // Reset mid-load, then a clean reload.
      do_reset();
      for (int i = 0; i < 6; i++) send(frame1[i], 0);
      do_reset();
      send_list(frame1, 1);
      settle();
      chk("t5 writes", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("t5 addr0", log_addr[0], 32'h0);
         chk("t5 data0", log_data[0], 32'h00000013);
         chk("t5 data1", log_data[1], 32'h02800093);
      end

      // Random small frames with random gaps and random leading noise.
      for (int t = 0; t < 20; t++) begin
         logic [7:0] fr[$];
         int n;
         do_reset();
         n = int'($urandom_range(0, 6));
         fr = {};
         for (int i = 0; i < 3; i++) fr.push_back(8'($urandom_range(0, 8'hA4)));
         fr.push_back(8'hA5);
         fr.push_back(8'(n));
         fr.push_back(($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00);
         for (int i = 0; i < 4 * n + 3; i++) fr.push_back(8'($urandom));
         send_list(fr, int'($urandom_range(0, 2)));
         settle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
